// File: rtl/rsa_pkg.sv
// Shared types and helpers for the word-serial Montgomery datapath.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } idx_state_t;

  function automatic int unsigned idx_width(input int unsigned data_width);
    return (data_width < 2) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/down_counter_to_zero.sv
// W-bit down counter: loads a start value, decrements to zero, then reloads on the next dec.
module down_counter_to_zero #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic [W-1:0] reload_val,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (ce) begin
      if (clr) begin
        r_cnt <= '0;
      end else if (load) begin
        r_cnt <= load_val;
      end else if (dec) begin
        // never underflows: zero wraps to the reload value instead
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        else             r_cnt <= reload_val;
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/index_streamer_from_t_sub_1.sv
// Streams descending (i, j) index pairs from (lim, lim) to (0, 0), j innermost, over valid/ready.
module index_streamer_from_t_sub_1
  import rsa_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 1025,
  localparam int unsigned W          = idx_width(DATA_WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] t_sub_1,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_i,
  output logic [W-1:0] o_j,
  output logic         o_first,
  output logic         o_row_end,
  output logic         o_last,
  output logic         o_busy,
  output logic         o_done
);

  idx_state_t   r_state;
  idx_state_t   w_next;
  logic [W-1:0] r_lim;
  logic [W-1:0] w_i;
  logic [W-1:0] w_j;
  logic         w_i_zero;
  logic         w_j_zero;
  logic         w_load;
  logic         w_jdec;
  logic         w_idec;
  logic         w_beat;

  assign w_load = (r_state == IDLE) && start;
  assign w_jdec = (r_state == RUN) && i_ready;
  assign w_idec = w_jdec && w_j_zero && !w_i_zero;
  assign w_beat = w_jdec && ce;

  // abort drives clr, which outranks both load and dec inside the counters
  down_counter_to_zero #(.W(W)) u_j_cnt (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .clr        (abort),
    .load       (w_load),
    .load_val   (t_sub_1),
    .dec        (w_jdec),
    .reload_val (r_lim),
    .o_cnt      (w_j),
    .o_zero     (w_j_zero)
  );

  down_counter_to_zero #(.W(W)) u_i_cnt (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .clr        (abort),
    .load       (w_load),
    .load_val   (t_sub_1),
    .dec        (w_idec),
    .reload_val (r_lim),
    .o_cnt      (w_i),
    .o_zero     (w_i_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lim   <= '0;
    end else if (ce) begin
      r_state <= w_next;
      if (abort)       r_lim <= '0;
      else if (w_load) r_lim <= t_sub_1;
    end
  end

  always_comb begin
    w_next = r_state;
    if (ce && abort) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (ce && start) w_next = RUN;
        RUN:     if (w_beat && w_j_zero && w_i_zero) w_next = DONE;
        DONE:    if (ce) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_valid   = (r_state == RUN);
    o_busy    = (r_state != IDLE);
    o_done    = (r_state == DONE);
    o_i       = o_valid ? w_i : '0;
    o_j       = o_valid ? w_j : '0;
    o_first   = o_valid && (w_i == r_lim) && (w_j == r_lim);
    o_row_end = o_valid && w_j_zero;
    o_last    = o_valid && w_i_zero && w_j_zero;
  end

endmodule

// File: tb/tb_index_streamer_from_t_sub_1.sv
// Scoreboard bench for the descending index streamer (DATA_WIDTH = 1025, W = 11).
module tb_index_streamer_from_t_sub_1;

  localparam int W = 11;

  typedef struct packed {
    logic [W-1:0] i;
    logic [W-1:0] j;
    logic         f;
    logic         r;
    logic         l;
  } pair_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce;
  logic         start;
  logic         abort;
  logic [W-1:0] t_sub_1;
  logic         i_ready;
  logic         o_valid;
  logic [W-1:0] o_i;
  logic [W-1:0] o_j;
  logic         o_first;
  logic         o_row_end;
  logic         o_last;
  logic         o_busy;
  logic         o_done;

  int    checks   = 0;
  int    failures = 0;
  pair_t sb[$];

  always #5 clk = ~clk;

  index_streamer_from_t_sub_1 #(.DATA_WIDTH(1025)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .start     (start),
    .abort     (abort),
    .t_sub_1   (t_sub_1),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_i       (o_i),
    .o_j       (o_j),
    .o_first   (o_first),
    .o_row_end (o_row_end),
    .o_last    (o_last),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  task automatic push_sweep(input int lim);
    pair_t p;
    for (int i = lim; i >= 0; i--) begin
      for (int j = lim; j >= 0; j--) begin
        p.i = W'(i);
        p.j = W'(j);
        p.f = (i == lim) && (j == lim);
        p.r = (j == 0);
        p.l = (i == 0) && (j == 0);
        sb.push_back(p);
      end
    end
  endtask

  task automatic start_sweep(input int lim);
    @(negedge clk);
    ce      = 1'b1;
    t_sub_1 = W'(lim);
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    push_sweep(lim);
  endtask

  // Runs one sweep to completion; poke_at injects a start with a new limit mid-run.
  task automatic run_sweep(input int max_cyc, input bit rnd, input int poke_at,
                           output int beats);
    pair_t        exp;
    logic [W-1:0] pi, pj;
    bit           pend, got;
    beats = 0; pend = 0; got = 0; pi = '0; pj = '0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      @(negedge clk);
      ce      = rnd ? ($urandom_range(0, 9) < 8) : 1'b1;
      i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start   = (c == poke_at);
      if (c == poke_at) t_sub_1 = W'(1);
      if (pend) begin
        checks++;
        if (o_valid !== 1'b1 || o_i !== pi || o_j !== pj) begin
          failures++;
          $display("FAIL stable: valid=%b i=%0d j=%0d required valid=1 i=%0d j=%0d",
                   o_valid, o_i, o_j, pi, pj);
        end
      end
      if (!o_valid) begin
        checks++;
        if ({o_i, o_j, o_first, o_row_end, o_last} !== '0) begin
          failures++;
          $display("FAIL idle_outputs: i=%0d j=%0d flags=%b%b%b required all 0",
                   o_i, o_j, o_first, o_row_end, o_last);
        end
      end
      if (o_valid && i_ready && ce) begin
        beats++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL extra_beat: got (%0d,%0d) required no beat", o_i, o_j);
        end else begin
          exp = sb.pop_front();
          if ({o_i, o_j, o_first, o_row_end, o_last} !== exp) begin
            failures++;
            $display("FAIL beat: got (%0d,%0d) f=%b r=%b l=%b required (%0d,%0d) f=%b r=%b l=%b",
                     o_i, o_j, o_first, o_row_end, o_last, exp.i, exp.j, exp.f, exp.r, exp.l);
          end
        end
      end
      pend = o_valid && !(i_ready && ce);
      pi   = o_i;
      pj   = o_j;
      if (o_done) begin
        checks++;
        if (o_busy !== 1'b1 || sb.size() != 0) begin
          failures++;
          $display("FAIL done_state: busy=%b pending=%0d required busy=1 pending=0",
                   o_busy, sb.size());
        end
        ce  = 1'b1;
        got = 1;
      end
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL timeout: no done after %0d cycles, beats=%0d", max_cyc, beats);
    end else begin
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
        failures++;
        $display("FAIL after_done: busy=%b done=%b required 0 0", o_busy, o_done);
      end
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; start = 1'b0; abort = 1'b0; i_ready = 1'b0; t_sub_1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_valid, o_i, o_j, o_first, o_row_end, o_last, o_busy, o_done} !== '0) begin
      failures++;
      $display("FAIL reset: valid=%b i=%0d j=%0d busy=%b done=%b required all 0",
               o_valid, o_i, o_j, o_busy, o_done);
    end
    rst = 1'b0;
    ce  = 1'b1;
  endtask

  task automatic test_basic();
    int beats;
    start_sweep(2);
    run_sweep(60, 0, -1, beats);
    checks++;
    if (beats !== 9) begin
      failures++;
      $display("FAIL basic_count: got %0d beats required 9", beats);
    end
  endtask

  task automatic test_single();
    start_sweep(0);
    @(negedge clk);
    ce = 1'b1; i_ready = 1'b1;
    checks++;
    if ({o_valid, o_i, o_j, o_first, o_row_end, o_last} !== {1'b1, 22'd0, 3'b111}) begin
      failures++;
      $display("FAIL single_beat: valid=%b (%0d,%0d) f=%b r=%b l=%b required 1 (0,0) 1 1 1",
               o_valid, o_i, o_j, o_first, o_row_end, o_last);
    end
    @(negedge clk);
    ce = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_done: done=%b valid=%b required 1 0", o_done, o_valid);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b1) begin
      failures++;
      $display("FAIL done_stretch: done=%b required 1 while ce=0", o_done);
    end
    ce = 1'b1;
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: done=%b busy=%b required 0 0", o_done, o_busy);
    end
    sb.delete();
  endtask

  task automatic test_random();
    int beats;
    start_sweep(3);
    run_sweep(600, 1, 5, beats);
    checks++;
    if (beats !== 16) begin
      failures++;
      $display("FAIL random_count: got %0d beats required 16", beats);
    end
  endtask

  task automatic test_abort();
    pair_t exp;
    int    beats;
    bit    aborted;
    beats = 0; aborted = 0;
    start_sweep(3);
    for (int c = 0; c < 100 && !aborted; c++) begin
      @(negedge clk);
      ce = 1'b1; i_ready = 1'b1;
      checks++;
      if (o_done !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_done: done=%b required 0", o_done);
      end
      if (beats == 4) begin
        abort   = 1'b1;
        aborted = 1;
      end else if (o_valid) begin
        exp = sb.pop_front();
        beats++;
        checks++;
        if ({o_i, o_j, o_first, o_row_end, o_last} !== exp) begin
          failures++;
          $display("FAIL abort_beat: got (%0d,%0d) required (%0d,%0d)", o_i, o_j, exp.i, exp.j);
        end
      end
    end
    if (!aborted) begin
      checks++;
      failures++;
      $display("FAIL abort_timeout: beats=%0d required 4 before abort", beats);
    end
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: busy=%b valid=%b done=%b required 0 0 0", o_busy, o_valid, o_done);
    end
    sb.delete();
    start_sweep(1);
    run_sweep(60, 0, -1, beats);
    checks++;
    if (beats !== 4) begin
      failures++;
      $display("FAIL restart_count: got %0d beats required 4", beats);
    end
  endtask

  task automatic test_rst_mid();
    pair_t exp;
    start_sweep(3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ce = 1'b1; i_ready = 1'b1;
      if (c == 2) t_sub_1 = W'(0);
      exp = sb.pop_front();
      checks++;
      if (o_valid !== 1'b1 || {o_i, o_j, o_first, o_row_end, o_last} !== exp) begin
        failures++;
        $display("FAIL rst_mid_beat: valid=%b got (%0d,%0d) required (%0d,%0d)",
                 o_valid, o_i, o_j, exp.i, exp.j);
      end
    end
    @(negedge clk);
    ce = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_valid, o_i, o_j, o_first, o_row_end, o_last, o_busy, o_done} !== '0) begin
      failures++;
      $display("FAIL rst_mid: valid=%b i=%0d j=%0d busy=%b done=%b required all 0",
               o_valid, o_i, o_j, o_busy, o_done);
    end
    rst = 1'b0; ce = 1'b1;
    sb.delete();
  endtask

  task automatic test_wide();
    int beats;
    start_sweep(31);
    run_sweep(1200, 0, -1, beats);
    checks++;
    if (beats !== 1024) begin
      failures++;
      $display("FAIL wide_count: got %0d beats required 1024", beats);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_random();
    test_abort();
    test_rst_mid();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
